// File: rtl/fir_mc_pkg.sv
// Shared constants, register map and FSM encoding for the multi-channel FIR engine.
package fir_mc_pkg;
  localparam int REG_CTRL   = 'h000;
  localparam int REG_LEN    = 'h010;
  localparam int REG_TAP    = 'h014;
  localparam int REG_SHIFT  = 'h018;
  localparam int REG_COEF   = 'h080;
  localparam int PROT_LO    = 'h010;
  localparam int PROT_HI    = 'h0FC;
  localparam int CTRL_START = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_IDLE  = 2;
  localparam int TID_W      = 3;
  localparam int SHIFT_W    = 5;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_IN, S_MAC, S_OUT, S_DONE} state_t;

  function automatic logic coef_hit(input logic [31:0] addr, input int max_taps);
    return addr >= REG_COEF && addr < REG_COEF + 4 * max_taps && addr[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/fir_mc_engine_if.sv
// AXI-Lite config bus plus AXI-Stream sample in/out for the FIR engine.
interface fir_mc_engine_if #(parameter int pADDR_WIDTH = 12, parameter int pDATA_WIDTH = 32);
  import fir_mc_pkg::*;
  logic                   awvalid, awready, wvalid, wready;
  logic [pADDR_WIDTH-1:0] awaddr, araddr;
  logic [pDATA_WIDTH-1:0] wdata, rdata;
  logic                   arvalid, arready, rvalid, rready;
  logic                   ss_tvalid, ss_tready;
  logic [pDATA_WIDTH-1:0] ss_tdata, sm_tdata;
  logic                   sm_tvalid, sm_tready, sm_tlast;
  logic [TID_W-1:0]       sm_tid;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready, ss_tvalid, ss_tdata, sm_tready,
    input  awready, wready, arready, rvalid, rdata, ss_tready, sm_tvalid, sm_tdata, sm_tid, sm_tlast
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready, ss_tvalid, ss_tdata, sm_tready,
    output awready, wready, arready, rvalid, rdata, ss_tready, sm_tvalid, sm_tdata, sm_tid, sm_tlast
  );
endinterface

// File: rtl/fir_mc_axil_regs.sv
// AXI-Lite register file: ctrl/status, run configuration and coefficient storage.
module fir_mc_axil_regs
  import fir_mc_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pMAX_TAPS   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  fir_mc_engine_if.slave                        bus,
  input  logic                                  idle,
  input  logic                                  done_set,
  output logic                                  start,
  output logic [pDATA_WIDTH-1:0]                data_length,
  output logic [pDATA_WIDTH-1:0]                tap_num,
  output logic [SHIFT_W-1:0]                    shift,
  output logic [pMAX_TAPS-1:0][pDATA_WIDTH-1:0] coef
);
  localparam int CIW = pMAX_TAPS > 1 ? $clog2(pMAX_TAPS) : 1;

  logic                   ap_done, wr_en, rd_en, wr_open;
  logic [31:0]            waddr, raddr;
  logic [CIW-1:0]         widx, ridx;
  logic [pDATA_WIDTH-1:0] rd_mux;

  assign waddr   = {{(32-pADDR_WIDTH){1'b0}}, bus.awaddr};
  assign raddr   = {{(32-pADDR_WIDTH){1'b0}}, bus.araddr};
  assign widx    = CIW'((waddr - 32'(REG_COEF)) >> 2);
  assign ridx    = CIW'((raddr - 32'(REG_COEF)) >> 2);
  assign wr_en   = bus.awready && bus.awvalid && bus.wvalid;
  assign rd_en   = bus.arready && bus.arvalid;
  // Config space is frozen while a run is in flight; ctrl stays writable.
  assign wr_open = idle || waddr < PROT_LO || waddr > PROT_HI;

  always_comb begin
    rd_mux = '0;
    if (raddr == REG_CTRL) begin
      rd_mux[CTRL_START] = start;
      rd_mux[CTRL_DONE]  = ap_done;
      rd_mux[CTRL_IDLE]  = idle;
    end
    else if (raddr == REG_LEN)           rd_mux = data_length;
    else if (raddr == REG_TAP)           rd_mux = tap_num;
    else if (raddr == REG_SHIFT)         rd_mux = pDATA_WIDTH'(shift);
    else if (coef_hit(raddr, pMAX_TAPS)) rd_mux = coef[ridx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      start       <= 1'b0;
      ap_done     <= 1'b0;
      data_length <= '0;
      tap_num     <= '0;
      shift       <= '0;
      coef        <= '0;
    end else begin
      bus.awready <= bus.awvalid && bus.wvalid && !bus.awready;
      bus.wready  <= bus.awvalid && bus.wvalid && !bus.awready;
      start       <= wr_en && waddr == REG_CTRL && bus.wdata[CTRL_START];
      if (wr_en && wr_open) begin
        if (waddr == REG_LEN)                data_length <= bus.wdata;
        else if (waddr == REG_TAP)           tap_num     <= bus.wdata;
        else if (waddr == REG_SHIFT)         shift       <= bus.wdata[SHIFT_W-1:0];
        else if (coef_hit(waddr, pMAX_TAPS)) coef[widx]  <= bus.wdata;
      end
      bus.arready <= bus.arvalid && !bus.arready && !bus.rvalid;
      if (rd_en) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= rd_mux;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end
      // A run finishing beats a simultaneous clear-on-read.
      if (done_set)                        ap_done <= 1'b1;
      else if (rd_en && raddr == REG_CTRL) ap_done <= 1'b0;
    end
  end
endmodule

// File: rtl/fir_mc_engine.sv
// Multi-channel interleaved FIR: one sample in, T serial MACs, one tagged sample out.
module fir_mc_engine
  import fir_mc_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pMAX_TAPS   = 16,
  parameter int pNUM_CH     = 2
) (
  input  logic           axis_clk,
  input  logic           axis_rst_n,
  fir_mc_engine_if.slave bus
);
  localparam int CIW = pMAX_TAPS > 1 ? $clog2(pMAX_TAPS) : 1;
  localparam int CHW = pNUM_CH > 1 ? $clog2(pNUM_CH) : 1;

  state_t                                             state, state_nx;
  logic                                               start, idle, done_set, last;
  logic                                               ss_fire, sm_fire, ss_tready, sm_tvalid, sm_tlast;
  logic [pDATA_WIDTH-1:0]                             data_length, tap_num, acc, count, prod, sm_tdata;
  logic [SHIFT_W-1:0]                                 shift;
  logic [TID_W-1:0]                                   sm_tid;
  logic [pMAX_TAPS-1:0][pDATA_WIDTH-1:0]              coef;
  logic [pNUM_CH-1:0][pMAX_TAPS-1:0][pDATA_WIDTH-1:0] dly;
  logic [CIW-1:0]                                     tap_idx, tap_last;
  logic [CHW-1:0]                                     ch;

  fir_mc_axil_regs #(
    .pADDR_WIDTH(pADDR_WIDTH), .pDATA_WIDTH(pDATA_WIDTH), .pMAX_TAPS(pMAX_TAPS)
  ) u_regs (
    .clk(axis_clk), .rst_n(axis_rst_n), .bus(bus), .idle(idle), .done_set(done_set),
    .start(start), .data_length(data_length), .tap_num(tap_num), .shift(shift), .coef(coef)
  );

  assign idle     = state == S_IDLE || state == S_DONE;
  // tap_num 0 runs a single tap, oversize values saturate at the storage depth.
  assign tap_last = (tap_num == '0) ? '0
                  : (tap_num >= pDATA_WIDTH'(pMAX_TAPS)) ? CIW'(pMAX_TAPS - 1)
                  : CIW'(tap_num - pDATA_WIDTH'(1));
  assign last     = count == data_length - pDATA_WIDTH'(1);
  assign prod     = coef[tap_idx] * dly[ch][tap_idx];
  assign ss_fire  = state == S_WAIT_IN && bus.ss_tvalid;
  assign sm_fire  = state == S_OUT && bus.sm_tready;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) state <= S_IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (state == S_DONE) state_nx = S_IDLE;
        if (start)           state_nx = (data_length == '0) ? S_DONE : S_WAIT_IN;
      end
      S_WAIT_IN: if (bus.ss_tvalid)        state_nx = S_MAC;
      S_MAC:     if (tap_idx == tap_last)  state_nx = S_OUT;
      S_OUT:     if (bus.sm_tready)        state_nx = last ? S_DONE : S_WAIT_IN;
      default:                             state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    sm_tdata  = '0;
    sm_tid    = '0;
    sm_tlast  = 1'b0;
    done_set  = 1'b0;
    case (state)
      S_WAIT_IN: ss_tready = 1'b1;
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tdata  = $signed(acc) >>> shift;
        sm_tid    = TID_W'(ch);
        sm_tlast  = last;
      end
      S_DONE:    done_set = 1'b1;
      default:   ;
    endcase
  end

  assign bus.ss_tready = ss_tready;
  assign bus.sm_tvalid = sm_tvalid;
  assign bus.sm_tdata  = sm_tdata;
  assign bus.sm_tid    = sm_tid;
  assign bus.sm_tlast  = sm_tlast;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      dly     <= '0;
      acc     <= '0;
      tap_idx <= '0;
      ch      <= '0;
      count   <= '0;
    end else begin
      if (start && idle) begin
        dly   <= '0;
        ch    <= '0;
        count <= '0;
      end
      if (ss_fire) begin
        for (int k = pMAX_TAPS - 1; k > 0; k--) dly[ch][k] <= dly[ch][k-1];
        dly[ch][0] <= bus.ss_tdata;
        acc        <= '0;
        tap_idx    <= '0;
      end
      if (state == S_MAC) begin
        acc     <= acc + prod;
        tap_idx <= tap_idx + CIW'(1);
      end
      if (sm_fire) begin
        count <= count + pDATA_WIDTH'(1);
        ch    <= (ch == CHW'(pNUM_CH - 1)) ? '0 : ch + CHW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fir_mc_engine.sv
// Directed + randomized bench for fir_mc_engine against a convolution reference model.
module tb_fir_mc_engine;
  localparam int NCH = 2;
  localparam int MT  = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] cf [MT];
  logic [31:0] smp_q [$];
  logic [31:0] got_q [$];
  logic [31:0] rd;
  int          n;
  bit          quiet;

  always #5 clk = ~clk;

  fir_mc_engine_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();

  fir_mc_engine #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pMAX_TAPS(MT), .pNUM_CH(NCH)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
    int k = 0;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    while (!bus.awready && k < 20) begin @(negedge clk); k++; end
    chk("wr_handshake", 32'(k < 20 && bus.wready), 32'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic axil_read(input logic [11:0] a, output logic [31:0] d);
    int k = 0;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1;
    while (!bus.arready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    while (!bus.rvalid && k < 40) begin @(negedge clk); k++; end
    chk("rd_handshake", 32'(k < 40), 32'd1);
    d = bus.rdata;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic prog(input int len, input int tap, input int sh);
    axil_write(12'h010, 32'(len));
    axil_write(12'h014, 32'(tap));
    axil_write(12'h018, 32'(sh));
    for (int i = 0; i < MT; i++) axil_write(12'h080 + 12'(4 * i), cf[i]);
  endtask

  // Model: y[c][n] = (sum_{i<T} coef[i] * x_c[n-i]) mod 2^32, then arithmetic >> shift.
  task automatic run_stream(input int tap_cfg, input int sh, input bit stall);
    logic [31:0] hist [NCH][MT];
    logic [31:0] acc, want, held;
    int          t, c, k2;
    bit          stable;
    t = (tap_cfg < 1) ? 1 : (tap_cfg > MT) ? MT : tap_cfg;
    for (int a = 0; a < NCH; a++) for (int b = 0; b < MT; b++) hist[a][b] = '0;
    got_q.delete();
    prog(smp_q.size(), tap_cfg, sh);
    axil_write(12'h000, 32'h1);
    for (int k = 0; k < smp_q.size(); k++) begin
      c = k % NCH;
      for (int i = MT - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
      hist[c][0] = smp_q[k];
      acc = '0;
      for (int i = 0; i < t; i++) acc = acc + cf[i] * hist[c][i];
      want = 32'($signed(acc) >>> sh);

      k2 = 0;
      @(negedge clk);
      while (!bus.ss_tready && k2 < 50) begin @(negedge clk); k2++; end
      chk("ss_tready_wait", 32'(k2 < 50), 32'd1);
      bus.ss_tdata = smp_q[k]; bus.ss_tvalid = 1'b1;
      @(posedge clk); #1;
      bus.ss_tvalid = 1'b0;
      k2 = 0;
      while (!bus.sm_tvalid && k2 < 100) begin @(negedge clk); k2++; end
      chk($sformatf("latency%0d", k), 32'(k2), 32'(t + 1));
      if (stall && k == 0) begin
        held = bus.sm_tdata; stable = 1'b1;
        axil_write(12'h080, 32'hDEAD_BEEF);
        repeat (20) begin
          @(negedge clk);
          stable &= (bus.sm_tdata === held) && bus.sm_tvalid && !bus.ss_tready;
        end
        chk("stall_stable", 32'(stable), 32'd1);
      end
      chk($sformatf("data%0d", k), bus.sm_tdata, want);
      chk($sformatf("tid%0d", k), 32'(bus.sm_tid), 32'(c));
      chk($sformatf("last%0d", k), 32'(bus.sm_tlast), 32'(k == smp_q.size() - 1));
      got_q.push_back(bus.sm_tdata);
      bus.sm_tready = 1'b1;
      @(posedge clk); #1;
      bus.sm_tready = 1'b0;
    end
    axil_read(12'h000, rd); chk("done_set", rd, 32'h6);
    axil_read(12'h000, rd); chk("done_clr", rd, 32'h4);
  endtask

  initial begin
    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0;
    bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
    bus.ss_tvalid = 0; bus.ss_tdata = '0; bus.sm_tready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready",   32'(bus.awready),   32'd0);
    chk("rst_arready",   32'(bus.arready),   32'd0);
    chk("rst_rvalid",    32'(bus.rvalid),    32'd0);
    chk("rst_ss_tready", 32'(bus.ss_tready), 32'd0);
    chk("rst_sm_tvalid", 32'(bus.sm_tvalid), 32'd0);
    chk("rst_sm_tdata",  bus.sm_tdata,       32'd0);
    chk("rst_sm_tlast",  32'(bus.sm_tlast),  32'd0);
    rst_n = 1'b1;
    axil_read(12'h000, rd); chk("ctrl_reset", rd, 32'h4);
    axil_write(12'h040, 32'h1234_5678);
    axil_read(12'h040, rd); chk("unmapped_rd", rd, 32'h0);

    // T=3 coef {1,2,3}; remaining taps random to prove they are excluded.
    foreach (cf[i]) cf[i] = $urandom;
    cf[0] = 32'd1; cf[1] = 32'd2; cf[2] = 32'd3;
    smp_q = '{32'd1, 32'd1, 32'd1, 32'd1};
    run_stream(3, 0, 1'b0);
    chk("t3_out0", got_q[0], 32'd1);
    chk("t3_out2", got_q[2], 32'd3);
    chk("t3_out3", got_q[3], 32'd3);

    // Two channels, coef {1,1}, with back-pressure and a blocked coef write.
    cf[0] = 32'd1; cf[1] = 32'd1;
    smp_q = '{32'd10, 32'd100, 32'd20, 32'd200};
    run_stream(2, 0, 1'b1);
    chk("ch_out0", got_q[0], 32'd10);
    chk("ch_out1", got_q[1], 32'd100);
    chk("ch_out2", got_q[2], 32'd30);
    chk("ch_out3", got_q[3], 32'd300);
    axil_read(12'h080, rd); chk("coef_protect", rd, 32'd1);

    // Arithmetic output shift on a negative accumulator.
    cf[0] = 32'hFFFF_FFF8;
    smp_q = '{32'd5};
    run_stream(1, 2, 1'b0);
    chk("shift_neg", got_q[0], 32'hFFFF_FFF6);

    // tap_num 0 acts as a single tap.
    foreach (cf[i]) cf[i] = $urandom;
    smp_q.delete();
    repeat (6) smp_q.push_back($urandom);
    run_stream(0, 0, 1'b0);

    // Randomized runs, tap_num occasionally beyond the storage depth.
    repeat (3) begin
      foreach (cf[i]) cf[i] = $urandom;
      smp_q.delete();
      repeat ($urandom_range(2, 8)) smp_q.push_back($urandom);
      run_stream(int'($urandom_range(1, 20)), int'($urandom_range(0, 31)), 1'b0);
    end

    // data_length 0: straight to done, no stream traffic.
    prog(0, 4, 0);
    axil_write(12'h000, 32'h1);
    quiet = 1'b1;
    repeat (10) begin @(negedge clk); quiet &= !bus.sm_tvalid && !bus.ss_tready; end
    chk("len0_quiet", 32'(quiet), 32'd1);
    axil_read(12'h000, rd); chk("len0_done", rd, 32'h6);
    axil_read(12'h000, rd); chk("len0_clr", rd, 32'h4);

    // Reset in the middle of a MAC burst.
    foreach (cf[i]) cf[i] = $urandom;
    prog(4, 16, 0);
    axil_write(12'h000, 32'h1);
    n = 0;
    @(negedge clk);
    while (!bus.ss_tready && n < 50) begin @(negedge clk); n++; end
    chk("mid_ss_wait", 32'(n < 50), 32'd1);
    bus.ss_tdata = 32'd7; bus.ss_tvalid = 1'b1;
    @(posedge clk); #1;
    bus.ss_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_sm_tvalid", 32'(bus.sm_tvalid), 32'd0);
    chk("mid_rst_ss_tready", 32'(bus.ss_tready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    axil_read(12'h000, rd); chk("mid_rst_ctrl", rd, 32'h4);
    axil_read(12'h014, rd); chk("mid_rst_tap",  rd, 32'h0);
    axil_read(12'h080, rd); chk("mid_rst_coef", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_mc_engine.md
# fir_mc_engine

Parametrised multi-channel FIR engine for the user project area: AXI-Lite configuration, AXI-Stream sample in/out, internal register-based tap and delay-line storage (no external BRAM). Generalises the single-channel 11-tap FIR to up to pMAX_TAPS runtime-selectable taps, pNUM_CH round-robin interleaved channels with per-channel history, programmable output shift, and channel-tagged output.

## Interface
- pADDR_WIDTH, 12, AXI-Lite address width
- pDATA_WIDTH, 32, sample/coefficient/accumulator width (two's complement)
- pMAX_TAPS, 16, tap storage depth
- pNUM_CH, 2, interleaved channels (1..8)
- axis_clk  in  1  sole clock
- axis_rst_n  in  1  asynchronous active-low reset
- awvalid/awready  in/out  1  write address handshake
- awaddr  in  pADDR_WIDTH  write address
- wvalid/wready  in/out  1  write data handshake
- wdata  in  pDATA_WIDTH  write data (byte masking done by wrapper)
- arvalid/arready  in/out  1  read address handshake
- araddr  in  pADDR_WIDTH  read address
- rvalid/rready  out/in  1  read data handshake
- rdata  out  pDATA_WIDTH  read data
- ss_tvalid/ss_tready  in/out  1  input sample handshake
- ss_tdata  in  pDATA_WIDTH  input sample
- sm_tvalid/sm_tready  out/in  1  output sample handshake
- sm_tdata  out  pDATA_WIDTH  filtered sample
- sm_tid  out  3  channel of sm_tdata
- sm_tlast  out  1  last output of the run

## Operation
- Registers: 0x00 ctrl (bit0 ap_start W1, self-clearing; bit1 ap_done RO, clear-on-read; bit2 ap_idle RO); 0x10 data_length (total samples, all channels); 0x14 tap_num; 0x18 shift (5 bits); 0x80+4*i coef[i], i<pMAX_TAPS. Unmapped reads 0; unmapped writes ignored.
- Writes to 0x10–0xFC ignored while not idle; reads always allowed.
- tap_num effective T = clamp(tap_num, 1, pMAX_TAPS).
- ap_start while idle: clear all delay lines, ch=0, count=0, ap_idle=0. ap_start while busy ignored.
- FSM IDLE -> WAIT_IN -> MAC -> OUT -> WAIT_IN | DONE -> IDLE.
- WAIT_IN: ss_tready=1; on handshake shift sample into delay line of ch (x[ch][0]).
- MAC: T cycles, acc += coef[i]*x[ch][i], i=0..T-1; product and sum truncated to pDATA_WIDTH (wrap).
- OUT: sm_tdata = acc >>> shift (arithmetic), sm_tid=ch, sm_tlast=(count==data_length-1); on accept count++, ch=(ch+1) mod pNUM_CH.
- DONE: ap_done=1, ap_idle=1.
- data_length==0: ap_start goes directly to DONE next cycle, no stream traffic.

## Timing
- Reset: awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast=0; rdata, sm_tdata, sm_tid=0; ap_idle=1, ap_done=0; coefs, delay lines, config regs=0.
- AXI-Lite write: awready and wready pulse together 1 cycle after awvalid&&wvalid; register updates that edge.
- AXI-Lite read: arready pulses 1 cycle after arvalid (no read outstanding); rvalid next cycle, held with stable rdata until rready.
- ap_done read-clear and DONE entry in same cycle: set wins.
- Stream latency: ss handshake at cycle c -> MAC c+1..c+T -> sm_tvalid at c+T+1; sm_tdata/sm_tid stable until sm_tready. Minimum period T+2 cycles per sample.
- Back-pressure: sm_tready low stalls in OUT; ss_tready stays 0.
- Reset asserted mid-run: immediate return to reset values; no partial output.

## Structure
- fir_mc_pkg: register offsets, ctrl bit indices, FSM state enum, MAX_CH_ID width.
- Sub-module fir_mc_axil_regs: AXI-Lite handshakes, register file, coef storage, busy write-protect; datapath/FSM in top.

## Test plan
- Reset -> ap_idle=1, all valids/readies 0; read 0x00 returns 0x4.
- T=3, coef{1,2,3}, shift 0, 1 ch, inputs 1,1,1,1 -> outputs 1,3,6,6; sm_tlast on 4th; ap_done then clears on second read.
- 2 ch, T=2, coef{1,1}, inputs 10,100,20,200 -> outputs 10/tid0, 100/tid1, 30/tid0, 300/tid1.
- shift=2, coef{-8}, input 5 -> output -10 (0xFFFFFFF6).
- sm_tready low 20 cycles in OUT -> sm_tdata stable, ss_tready 0; coef write during run ignored (readback unchanged).
- data_length=0 ap_start -> ap_done within 2 cycles, no sm_tvalid; tap_num=0 behaves as T=1.
